// File: rtl/audio_pkg.sv
// Shared types and helpers for the I2S audio transmitter.
package audio_pkg;

  localparam int I2S_BITS_PER_FRAME = 32;
  localparam int SAMPLE_W           = 16;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] l;
    logic signed [SAMPLE_W-1:0] r;
  } stereo_sample_t;

  // Sum in 17 bits so L+R cannot overflow, then halve once more than the
  // requested attenuation; the result is truncated, not saturated.
  function automatic logic signed [SAMPLE_W-1:0] mono_mix(
    input logic signed [SAMPLE_W-1:0] l,
    input logic signed [SAMPLE_W-1:0] r,
    input int unsigned                shift
  );
    logic signed [SAMPLE_W:0] sum;
    logic signed [SAMPLE_W:0] scaled;
    sum    = {l[SAMPLE_W-1], l} + {r[SAMPLE_W-1], r};
    scaled = sum >>> (shift + 1);
    return scaled[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample producer -> I2S transmitter valid/ready channel.
interface audio_i2s_tx_if;
  import audio_pkg::*;

  logic signed [SAMPLE_W-1:0] sample_l;
  logic signed [SAMPLE_W-1:0] sample_r;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (output sample_l, sample_r, sample_valid, input sample_ready);
  modport slave  (input sample_l, sample_r, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_bclk_gen.sv
// Fractional phase-accumulator BCK generator; rise/fall flag the edge that
// the next clk will produce.
module i2s_bclk_gen
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 28636400,
  parameter int unsigned SAMPLE_RATE = 48000
) (
  input  logic clk,
  input  logic rst_n,
  output logic bck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned INC = 2 * SAMPLE_RATE * I2S_BITS_PER_FRAME;

  if (CLK_HZ < 2 * INC) begin : g_bad_ratio
    $error("i2s_bclk_gen: CLK_HZ must be at least twice the BCK toggle rate");
  end

  logic [31:0] acc_q, acc_d;
  logic        bck_q, bck_d;
  logic [32:0] sum;
  logic [32:0] wrapped;
  logic        toggle;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, INC};
    wrapped = sum - {1'b0, CLK_HZ};
    toggle  = (sum >= {1'b0, CLK_HZ});
    acc_d   = toggle ? wrapped[31:0] : sum[31:0];
    bck_d   = bck_q ^ toggle;
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      bck_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      bck_q <= bck_d;
    end
  end

  assign bck_o  = bck_q;
  assign rise_o = toggle & ~bck_q;
  assign fall_o = toggle &  bck_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// Philips-I2S transmitter with one-entry sample holding register, underrun
// replay and amplifier enable.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 28636400,
  parameter int unsigned SAMPLE_RATE = 48000,
  parameter int unsigned STEREO      = 1,
  parameter int unsigned AUDIO_SHIFT = 2,
  parameter int unsigned AMP_EN_LOW  = 1
) (
  input  logic           clk,
  input  logic           pll_lock,
  audio_i2s_tx_if.slave  smp_if,
  input  logic           mute,
  output logic           hp_bck,
  output logic           hp_ws,
  output logic           hp_din,
  output logic           pa_en,
  output logic           frame_start,
  output logic           underrun
);

  logic bck_rise, bck_fall;

  i2s_bclk_gen #(
    .CLK_HZ      (CLK_HZ),
    .SAMPLE_RATE (SAMPLE_RATE)
  ) u_bclk (
    .clk    (clk),
    .rst_n  (pll_lock),
    .bck_o  (hp_bck),
    .rise_o (bck_rise),
    .fall_o (bck_fall)
  );

  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [31:0]    shift_q, shift_d;
  logic           ws_q, ws_d;
  logic           din_q, din_d;
  stereo_sample_t hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  stereo_sample_t last_q, last_d;
  logic           ready_q, ready_d;
  logic           en_q;
  logic           underrun_q, underrun_d;

  logic           load;
  logic           capture;
  stereo_sample_t cap_sample;
  stereo_sample_t src;
  stereo_sample_t frame_word;

  always_comb begin
    load    = bck_fall && (bit_cnt_q == 5'd31);
    capture = smp_if.sample_valid && ready_q;

    if (STEREO != 0) begin
      cap_sample.l = smp_if.sample_l;
      cap_sample.r = smp_if.sample_r;
    end else begin
      cap_sample.l = mono_mix(smp_if.sample_l, smp_if.sample_r, AUDIO_SHIFT);
      cap_sample.r = cap_sample.l;
    end

    // An empty holding register at load time replays the previous sample.
    src        = hold_full_q ? hold_q : last_q;
    frame_word = mute ? '0 : src;

    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ws_d        = ws_q;
    din_d       = din_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    underrun_d  = underrun_q;

    if (bck_fall) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      ws_d      = (bit_cnt_d >= 5'd15) && (bit_cnt_d <= 5'd30);
      if (load) begin
        din_d   = frame_word[31];
        shift_d = {frame_word[30:0], 1'b0};
      end else begin
        din_d   = shift_q[31];
        shift_d = {shift_q[30:0], 1'b0};
      end
    end

    if (load) begin
      last_d      = src;
      hold_full_d = 1'b0;
      if (!hold_full_q) underrun_d = 1'b1;
    end

    // Capture after load: a same-clk capture refills the slot just drained.
    if (capture) begin
      hold_d      = cap_sample;
      hold_full_d = 1'b1;
    end

    ready_d = !hold_full_d;
  end

  // NOTE: the holding and last-sample registers are ordinary flops, so they
  // are reset like the rest of the state (a frame after reset sends zeros).
  always_ff @(posedge clk or negedge pll_lock) begin
    if (!pll_lock) begin
      bit_cnt_q   <= 5'd31;
      shift_q     <= '0;
      ws_q        <= 1'b0;
      din_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      ready_q     <= 1'b0;
      en_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ws_q        <= ws_d;
      din_q       <= din_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      ready_q     <= ready_d;
      en_q        <= 1'b1;
      underrun_q  <= underrun_d;
    end
  end

  assign hp_ws               = ws_q;
  assign hp_din              = din_q;
  assign smp_if.sample_ready = ready_q;
  assign pa_en               = (AMP_EN_LOW != 0) ? ~en_q : en_q;
  assign frame_start         = load;
  assign underrun            = underrun_q;

  a_edges_exclusive : assert property (@(posedge clk) disable iff (!pll_lock)
    !(bck_rise && bck_fall));

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench: stereo, mono-mix and default-rate instances of audio_i2s_tx.
module tb_audio_i2s_tx;

  localparam logic [31:0] WS_PATTERN = 32'h0001_FFFE;

  logic clk = 1'b0;
  logic rst_n, rst_def_n;
  always #5 clk = ~clk;

  audio_i2s_tx_if st_if ();
  audio_i2s_tx_if mo_if ();
  audio_i2s_tx_if df_if ();

  logic st_mute, mo_mute, df_mute;
  logic st_bck, st_ws, st_din, st_pa, st_fs, st_ur;
  logic mo_bck, mo_ws, mo_din, mo_pa, mo_fs, mo_ur;
  logic df_bck, df_ws, df_din, df_pa, df_fs, df_ur;

  audio_i2s_tx #(.CLK_HZ(6144000), .SAMPLE_RATE(48000), .STEREO(1), .AUDIO_SHIFT(2),
                 .AMP_EN_LOW(1)) u_st (
    .clk(clk), .pll_lock(rst_n), .smp_if(st_if), .mute(st_mute),
    .hp_bck(st_bck), .hp_ws(st_ws), .hp_din(st_din), .pa_en(st_pa),
    .frame_start(st_fs), .underrun(st_ur));

  audio_i2s_tx #(.CLK_HZ(6144000), .SAMPLE_RATE(48000), .STEREO(0), .AUDIO_SHIFT(2),
                 .AMP_EN_LOW(1)) u_mo (
    .clk(clk), .pll_lock(rst_n), .smp_if(mo_if), .mute(mo_mute),
    .hp_bck(mo_bck), .hp_ws(mo_ws), .hp_din(mo_din), .pa_en(mo_pa),
    .frame_start(mo_fs), .underrun(mo_ur));

  audio_i2s_tx u_df (
    .clk(clk), .pll_lock(rst_def_n), .smp_if(df_if), .mute(df_mute),
    .hp_bck(df_bck), .hp_ws(df_ws), .hp_din(df_din), .pa_en(df_pa),
    .frame_start(df_fs), .underrun(df_ur));

  int checks = 0;
  int errors = 0;
  logic [31:0] st_q[$];
  logic [31:0] mo_q[$];
  bit df_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Shift in hp_din/hp_ws on the next 32 BCK rises; abort on reset.
  task automatic collect(input bit mono, output logic [31:0] d, output logic [31:0] w,
                         output bit ok);
    int n = 0;
    int guard = 0;
    logic pb, b;
    ok = 1'b1;
    d  = '0;
    w  = '0;
    pb = mono ? mo_bck : st_bck;
    while (n < 32) begin
      @(negedge clk);
      if (!rst_n) begin
        ok = 1'b0;
        return;
      end
      b = mono ? mo_bck : st_bck;
      if (b && !pb) begin
        d = {d[30:0], (mono ? mo_din : st_din)};
        w = {w[30:0], (mono ? mo_ws : st_ws)};
        n++;
      end
      pb = b;
      guard++;
      if (guard > 400) begin
        check(mono ? "mo_bck_timeout" : "st_bck_timeout", 32'(n), 32);
        ok = 1'b0;
        return;
      end
    end
  endtask

  initial begin : st_monitor
    logic [31:0] d, w, exp;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && st_fs === 1'b1) begin
        collect(1'b0, d, w, ok);
        if (ok && st_q.size() > 0) begin
          exp = st_q.pop_front();
          check("st_frame_data", d, exp);
          check("st_frame_ws", w, WS_PATTERN);
        end
      end
    end
  end

  initial begin : mo_monitor
    logic [31:0] d, w, exp;
    bit ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mo_fs === 1'b1) begin
        collect(1'b1, d, w, ok);
        if (ok && mo_q.size() > 0) begin
          exp = mo_q.pop_front();
          check("mo_frame_data", d, exp);
          check("mo_frame_ws", w, WS_PATTERN);
        end
      end
    end
  end

  initial begin : st_period
    time t0;
    wait (rst_n === 1'b1);
    @(posedge st_fs);
    t0 = $time;
    @(posedge st_fs);
    check("st_frame_period", 32'(($time - t0) / 10), 128);
  end

  initial begin : df_period
    time t0;
    wait (rst_def_n === 1'b1);
    @(posedge df_fs);
    t0 = $time;
    for (int i = 0; i < 5; i++) begin
      @(posedge df_fs);
      check_range("df_frame_period", int'(($time - t0) / 10), 596, 597);
      t0 = $time;
    end
    df_done = 1'b1;
  end

  initial begin : watchdog
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic wait_fs();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (st_fs !== 1'b1 && n < 300);
    check("st_frame_start_seen", 32'(st_fs), 1);
  endtask

  initial begin : stimulus
    int n, toggles;
    logic pb;
    st_if.sample_valid = 1'b0; st_if.sample_l = '0; st_if.sample_r = '0;
    mo_if.sample_valid = 1'b0; mo_if.sample_l = '0; mo_if.sample_r = '0;
    df_if.sample_valid = 1'b0; df_if.sample_l = '0; df_if.sample_r = '0;
    st_mute = 1'b0; mo_mute = 1'b0; df_mute = 1'b0;
    rst_n = 1'b1; rst_def_n = 1'b1;
    #1;
    rst_n = 1'b0; rst_def_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'({st_bck, st_ws, st_din, st_if.sample_ready, st_fs, st_ur}), 0);
    check("reset_pa_en", 32'(st_pa), 1);

    // Release and immediately offer the first samples.
    rst_n = 1'b1; rst_def_n = 1'b1;
    check("ready_low_at_release", 32'(st_if.sample_ready), 0);
    st_if.sample_valid = 1'b1; st_if.sample_l = 16'sh8001; st_if.sample_r = 16'sh7FFE;
    mo_if.sample_valid = 1'b1; mo_if.sample_l = 16'sh4000; mo_if.sample_r = 16'sh4000;
    st_q.push_back(32'h8001_7FFE);
    mo_q.push_back(32'h1000_1000);
    @(negedge clk);
    check("ready_1clk_after_release", 32'(st_if.sample_ready), 1);
    check("pa_en_enabled", 32'(st_pa), 0);
    @(negedge clk);
    st_if.sample_valid = 1'b0;
    mo_if.sample_valid = 1'b0;
    check("ready_drops_after_capture", 32'(st_if.sample_ready), 0);

    // F1 loads the captured sample; F2 will replay it.
    wait_fs();
    @(negedge clk);
    check("no_underrun_after_f1", 32'(st_ur), 0);
    check("ready_after_f1_load", 32'(st_if.sample_ready), 1);
    st_q.push_back(32'h8001_7FFE);
    mo_if.sample_valid = 1'b1; mo_if.sample_l = 16'shC000; mo_if.sample_r = 16'shC000;
    mo_q.push_back(32'hF000_F000);
    @(negedge clk);
    mo_if.sample_valid = 1'b0;

    wait_fs();
    @(negedge clk);
    check("underrun_set_f2", 32'(st_ur), 1);
    st_if.sample_valid = 1'b1; st_if.sample_l = 16'sh1234; st_if.sample_r = 16'sh5678;
    st_q.push_back(32'h1234_5678);
    @(negedge clk);
    st_if.sample_valid = 1'b0;
    check("ready_low_holding_full", 32'(st_if.sample_ready), 0);
    toggles = 0;
    pb = st_bck;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (st_bck !== pb) toggles++;
      pb = st_bck;
    end
    check("bck_toggles_per_32clk", 32'(toggles), 16);

    // Valid arrives in the load clk while the holding register is full.
    wait_fs();
    check("ready_low_at_full_load", 32'(st_if.sample_ready), 0);
    st_if.sample_valid = 1'b1; st_if.sample_l = 16'shA5A5; st_if.sample_r = 16'sh5A5A;
    st_q.push_back(32'hA5A5_5A5A);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (st_if.sample_ready !== 1'b1 && n < 10);
    check("ready_clks_after_load", 32'(n), 1);
    @(negedge clk);
    st_if.sample_valid = 1'b0;
    check("ready_low_after_b", 32'(st_if.sample_ready), 0);

    // F4 sends B; in F5's load clk capture and underrun replay coincide.
    wait_fs();
    wait_fs();
    check("ready_high_empty_load", 32'(st_if.sample_ready), 1);
    st_if.sample_valid = 1'b1; st_if.sample_l = 16'sh0F0F; st_if.sample_r = 16'shF0F0;
    st_q.push_back(32'hA5A5_5A5A);
    st_q.push_back(32'h0F0F_F0F0);
    @(negedge clk);
    st_if.sample_valid = 1'b0;
    check("holding_full_same_clk", 32'(st_if.sample_ready), 0);
    check("underrun_sticky", 32'(st_ur), 1);

    // Muted load transmits zeros.
    wait_fs();
    @(negedge clk);
    st_mute = 1'b1;
    st_if.sample_valid = 1'b1; st_if.sample_l = 16'sh7FFF; st_if.sample_r = 16'sh8000;
    st_q.push_back(32'h0000_0000);
    @(negedge clk);
    st_if.sample_valid = 1'b0;
    wait_fs();
    @(negedge clk);
    st_mute = 1'b0;

    // Abort F8 around bit 9 with an asynchronous reset.
    wait_fs();
    repeat (39) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midframe_reset_outputs",
          32'({st_bck, st_ws, st_din, st_if.sample_ready, st_fs, st_ur}), 0);
    check("midframe_reset_pa_en", 32'(st_pa), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("ready_low_at_rerelease", 32'(st_if.sample_ready), 0);
    st_q.push_back(32'h0000_0000);
    @(negedge clk);
    check("ready_after_rerelease", 32'(st_if.sample_ready), 1);
    check("underrun_cleared", 32'(st_ur), 0);

    n = 0;
    while ((st_q.size() != 0 || mo_q.size() != 0 || !df_done) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("st_queue_drained", 32'(st_q.size()), 0);
    check("mo_queue_drained", 32'(mo_q.size()), 0);
    check("df_periods_done", 32'(df_done), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
